// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared FSM encoding and sizing helpers  |  Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Step counter must hold 0..STEPS; never collapse to zero width.
  function automatic int cnt_width(input int steps);
    int w;
    w = clog2(steps + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// ============================================================================
// fa_cell : combinational 1-bit full adder  |  Rev 1.0
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic carry_o
);

  logic w_axb;

  assign w_axb   = a_i ^ b_i;
  assign sum_o   = w_axb ^ cin_i;
  assign carry_o = (a_i & b_i) | (cin_i & w_axb);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : digit-serial add/subtract on valid/ready streams  |  Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cint_q, cint_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] digit_sum;
  logic [WIDTH-1:0] sum_shift;

  assign chain[0] = cint_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    fa_cell u_fa (
      .a_i     (a_q[i]),
      .b_i     (b_q[i]),
      .cin_i   (chain[i]),
      .sum_o   (digit_sum[i]),
      .carry_o (chain[i+1])
    );
  end

  // Result digits enter at the MSB end so the LSB digit lands at bit 0 last.
  if (DIGIT == WIDTH) begin : g_full_digit
    assign sum_shift = digit_sum;
  end else begin : g_part_digit
    assign sum_shift = {digit_sum, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cint_d  = cint_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          cint_d  = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d  = sum_shift;
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        cint_d = chain[DIGIT];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          // On the last step the top cell of the chain is the word MSB.
          carry_d = chain[DIGIT];
          ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cint_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cint_q  <= cint_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : randomized and directed checks against an arithmetic model
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=1 DIGIT=1, instance 1: WIDTH=8 DIGIT=1, instance 2: WIDTH=8 DIGIT=4
  logic       iv[3], ordy[3], cinv[3], subv[3];
  logic       ir[3], ov[3], cy[3], of[3];
  logic [0:0] a_w1, b_w1, sum_w1;
  logic [7:0] av[1:2], bv[1:2], s8[1:2];

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_w1), .b(b_w1),
    .cin(cinv[0]), .sub(subv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sum_w1), .carry(cy[0]), .overflow(of[0]));

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .cin(cinv[1]), .sub(subv[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(s8[1]), .carry(cy[1]), .overflow(of[1]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
    .cin(cinv[2]), .sub(subv[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(s8[2]), .carry(cy[2]), .overflow(of[2]));

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
  function automatic void ref_op(input int w, input int a_i, input int b_i, input int c_i,
                                 input int s_i, output int sum_r, output int carry_r,
                                 output int ovf_r);
    int m, res, sa, sb, sr;
    m       = 1 << w;
    res     = s_i ? (a_i - b_i - c_i) : (a_i + b_i + c_i);
    carry_r = s_i ? int'(res >= 0) : int'(res >= m);
    sum_r   = ((res % m) + m) % m;
    sa      = (a_i >= m / 2) ? a_i - m : a_i;
    sb      = (b_i >= m / 2) ? b_i - m : b_i;
    sr      = s_i ? (sa - sb - c_i) : (sa + sb + c_i);
    ovf_r   = int'((sr < -(m / 2)) || (sr > (m / 2 - 1)));
  endfunction

  function automatic logic [7:0] rd_sum(input int k);
    return (k == 0) ? {7'b0, sum_w1} : s8[k];
  endfunction

  task automatic drive_in(input int k, input logic v, input logic [7:0] a_in,
                          input logic [7:0] b_in, input logic c_in, input logic s_in);
    iv[k]   = v;
    cinv[k] = c_in;
    subv[k] = s_in;
    if (k == 0) begin
      a_w1 = a_in[0:0];
      b_w1 = b_in[0:0];
    end else begin
      av[k] = a_in;
      bv[k] = b_in;
    end
  endtask

  // One full transaction; operands are scrambled right after acceptance.
  task automatic do_op(input int k, input logic [7:0] a_in, input logic [7:0] b_in,
                       input logic c_in, input logic s_in, output logic [7:0] s_o,
                       output logic c_o, output logic o_o, output int lat);
    ordy[k] = 1'b0;
    drive_in(k, 1'b1, a_in, b_in, c_in, s_in);
    @(posedge clk); #1;
    drive_in(k, 1'b0, ~a_in, ~b_in, ~c_in, ~s_in);
    lat = 0;
    while (!ov[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    s_o = rd_sum(k);
    c_o = cy[k];
    o_o = of[k];
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ir[k], ov[k], cy[k], of[k]} !== 4'b1000 || rd_sum(k) !== 8'h00) begin
        errors++;
        $display("FAIL reset_state inst=%0d got ir=%b ov=%b c=%b o=%b sum=%h exp ir=1 ov=0 c=0 o=0 sum=00",
                 k, ir[k], ov[k], cy[k], of[k], rd_sum(k));
      end
    end
  endtask

  task automatic test_w1_truth;
    logic [7:0] s; logic c, o; int lat, es, ec, eo;
    for (int i = 0; i < 8; i++) begin
      ref_op(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, 0, es, ec, eo);
      do_op(0, 8'((i >> 2) & 1), 8'((i >> 1) & 1), 1'(i & 1), 1'b0, s, c, o, lat);
      checks++;
      if ({c, s[0], o} !== {1'(ec), 1'(es), 1'(eo)} || lat != 1) begin
        errors++;
        $display("FAIL w1_truth abc=%03b got c=%b s=%b o=%b lat=%0d exp c=%0d s=%0d o=%0d lat=1",
                 3'(i), c, s[0], o, lat, ec, es, eo);
      end
    end
  endtask

  task automatic test_w8_directed;
    logic [7:0] ta[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
    logic [7:0] tb[4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
    logic       ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es[4] = '{8'h96, 8'h00, 8'hF0, 8'h7F};
    logic       ec[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] s; logic c, o; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(1, ta[i], tb[i], 1'b0, ts[i], s, c, o, lat);
      checks++;
      if ({s, c, o} !== {es[i], ec[i], eo[i]} || lat != 8) begin
        errors++;
        $display("FAIL w8d1_vec%0d got sum=%h c=%b o=%b lat=%0d exp sum=%h c=%b o=%b lat=8",
                 i, s, c, o, lat, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_digit4;
    logic [7:0] s; logic c, o; int lat;
    do_op(2, 8'hF0, 8'h0F, 1'b1, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h00, 1'b1, 1'b0} || lat != 2) begin
      errors++;
      $display("FAIL w8d4_vec got sum=%h c=%b o=%b lat=%0d exp sum=00 c=1 o=0 lat=2", s, c, o, lat);
    end
  endtask

  task automatic test_random(input int k, input int n, input int exp_lat);
    logic [7:0] ra, rb, s; logic rc, rs, c, o; int lat, es, ec, eo;
    for (int i = 0; i < n; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      ref_op(8, int'(ra), int'(rb), int'(rc), int'(rs), es, ec, eo);
      do_op(k, ra, rb, rc, rs, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {8'(es), 1'(ec), 1'(eo)} || lat != exp_lat) begin
        errors++;
        $display("FAIL random inst=%0d a=%h b=%h cin=%b sub=%b got sum=%h c=%b o=%b lat=%0d exp sum=%h c=%0d o=%0d lat=%0d",
                 k, ra, rb, rc, rs, s, c, o, lat, 8'(es), ec, eo, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat; logic bad;
    ordy[1] = 1'b0;
    drive_in(1, 1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    lat = 0;
    while (!ov[1] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ov[1], ir[1], s8[1], cy[1], of[1]} !== {1'b1, 1'b0, 8'h96, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b sum=%h c=%b o=%b exp ov=1 ir=0 sum=96 c=0 o=1",
                 i, ov[1], ir[1], s8[1], cy[1], of[1]);
      end
      drive_in(1, (i == 2), 8'h01, 8'h01, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    checks++;
    if ({ir[1], ov[1]} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", ir[1], ov[1]);
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ov[1] !== 1'b0 || ir[1] !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_ignored_pulse got activity after release exp idle with ov=0 ir=1");
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [7:0] s; logic c, o; int lat; logic bad;
    drive_in(1, 1'b1, 8'hC3, 8'h5A, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({ir[1], ov[1], s8[1], cy[1], of[1]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_busy got ir=%b ov=%b sum=%h c=%b o=%b exp ir=1 ov=0 sum=00 c=0 o=0",
               ir[1], ov[1], s8[1], cy[1], of[1]);
    end
    bad = 1'b0;
    ordy[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (ov[1] !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    ordy[1] = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_no_stale_valid got out_valid=1 after reset exp 0");
    end
    do_op(1, 8'h01, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h02, 1'b0, 1'b0} || lat != 8) begin
      errors++;
      $display("FAIL rst_then_op got sum=%h c=%b o=%b lat=%0d exp sum=02 c=0 o=0 lat=8", s, c, o, lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ordy[k] = 1'b0;
      drive_in(k, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_w1_truth;
    test_w8_directed;
    test_digit4;
    test_random(1, 20, 8);
    test_random(2, 20, 2);
    test_backpressure;
    test_reset_mid_busy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
